id_issue_ctrl: RTL

- ID-stage controller for the RV32I pipeline.
- Owns the ID/EX pipeline register and instantiates the immediate generator.
- Selects the single immediate the instruction's format requires and derives EX control bits.
- Sequences issue into EX with valid/ready handshakes, load-use bubble insertion and branch flush.

---
 rtl/id_issue_ctrl_pkg.sv | 59 +++++
 rtl/id_issue_ctrl_if.sv | 42 ++++
 rtl/id_issue_ctrl_immediategen.sv | 16 +
 rtl/id_issue_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the RV32I ID-stage issue controller: opcodes,
// immediate formats, FSM states and the ID/EX register layout.
package id_issue_ctrl_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_SB,
    IMM_UJ,
    IMM_U,
    IMM_NONE
  } imm_fmt_e;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } issue_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ex_bundle_t;

  // OP (R-type) also maps to IMM_NONE; the caller separates it from illegal.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: return IMM_I;
      STORE:                      return IMM_S;
      BRANCH:                     return IMM_SB;
      JAL:                        return IMM_UJ;
      LUI, AUIPC:                 return IMM_U;
      default:                    return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// IF/ID-to-EX handshake bundle: upstream instruction offer, flush, and the
// registered ID/EX outputs.
interface id_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_alu_src;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;
  logic            stall_active;

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7b5, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_illegal, stall_active
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7b5, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_illegal, stall_active
  );
endinterface

// File: rtl/id_issue_ctrl_immediategen.sv
// RV32I immediate generator: every sign-extended immediate format decoded
// in parallel from one instruction word.
module immediategen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_sb,
  output logic [31:0] imm_uj,
  output logic [31:0] imm_u
);
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_sb = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_uj = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: decodes the IF/ID instruction, owns the ID/EX
// register and sequences issue with load-use bubbles and branch flush.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  id_issue_ctrl_if.slave bus
);
  logic [XLEN-1:0] imm_i, imm_s, imm_sb, imm_uj, imm_u;
  logic [6:0]      opcode;
  imm_fmt_e        fmt;
  ex_bundle_t      dec;
  logic            uses_rs1, uses_rs2;
  logic            slot_free, hazard, id_ready, accept;

  issue_state_e    state_reg;
  logic [1:0]      cnt_reg;
  logic            ex_valid_reg;
  ex_bundle_t      ex_reg;

  immediategen u_immgen (
    .instr  (bus.if_instr),
    .imm_i  (imm_i),
    .imm_s  (imm_s),
    .imm_sb (imm_sb),
    .imm_uj (imm_uj),
    .imm_u  (imm_u)
  );

  assign opcode = bus.if_instr[6:0];
  assign fmt    = imm_fmt_of(opcode);

  always_comb begin
    dec          = '0;
    dec.pc       = bus.if_pc;
    dec.rs1      = bus.if_instr[19:15];
    dec.rs2      = bus.if_instr[24:20];
    dec.rd       = bus.if_instr[11:7];
    dec.funct3   = bus.if_instr[14:12];
    dec.funct7b5 = bus.if_instr[30];
    case (fmt)
      IMM_I:   dec.imm = imm_i;
      IMM_S:   dec.imm = imm_s;
      IMM_SB:  dec.imm = imm_sb;
      IMM_UJ:  dec.imm = imm_uj;
      IMM_U:   dec.imm = imm_u;
      default: dec.imm = '0;
    endcase
    // The ALU second operand is the immediate for I, S and U; JAL adds PC+4.
    dec.alu_src   = fmt inside {IMM_I, IMM_S, IMM_U};
    dec.mem_read  = (opcode == LOAD);
    dec.mem_write = (opcode == STORE);
    dec.branch    = (opcode == BRANCH);
    dec.jump      = (opcode == JAL) || (opcode == JALR);
    dec.illegal   = (fmt == IMM_NONE) && (opcode != OP);
    dec.reg_write = !dec.illegal && !(fmt inside {IMM_S, IMM_SB});
    uses_rs1      = !(fmt inside {IMM_U, IMM_UJ});
    uses_rs2      = (opcode == OP) || (fmt inside {IMM_S, IMM_SB});
  end

  assign slot_free = !ex_valid_reg || bus.ex_ready;
  assign hazard    = ex_valid_reg && ex_reg.mem_read && (ex_reg.rd != 5'd0) && bus.if_valid &&
                     ((uses_rs1 && (dec.rs1 == ex_reg.rd)) || (uses_rs2 && (dec.rs2 == ex_reg.rd)));
  assign id_ready  = !rst && (state_reg == ST_RUN) && slot_free && !hazard && !bus.flush;
  assign accept    = bus.if_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      cnt_reg      <= '0;
      ex_valid_reg <= 1'b0;
      ex_reg       <= '0;
    end else if (bus.flush) begin
      ex_valid_reg <= 1'b0;
      state_reg    <= ST_RUN;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accept) begin
            ex_reg       <= dec;
            ex_valid_reg <= 1'b1;
          end else if (slot_free) begin
            ex_valid_reg <= 1'b0;
          end
          // The hazard cycle itself is the first bubble; STALL adds the rest.
          if (hazard && slot_free && (LOAD_USE_BUBBLES > 1)) begin
            state_reg <= ST_STALL;
            cnt_reg   <= 2'(LOAD_USE_BUBBLES - 1);
          end
        end
        ST_STALL: begin
          ex_valid_reg <= 1'b0;
          cnt_reg      <= cnt_reg - 2'd1;
          if (cnt_reg == 2'd1) state_reg <= ST_RUN;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_pc        = ex_reg.pc;
  assign bus.ex_imm       = ex_reg.imm;
  assign bus.ex_rs1       = ex_reg.rs1;
  assign bus.ex_rs2       = ex_reg.rs2;
  assign bus.ex_rd        = ex_reg.rd;
  assign bus.ex_funct3    = ex_reg.funct3;
  assign bus.ex_funct7b5  = ex_reg.funct7b5;
  assign bus.ex_alu_src   = ex_reg.alu_src;
  assign bus.ex_mem_read  = ex_reg.mem_read;
  assign bus.ex_mem_write = ex_reg.mem_write;
  assign bus.ex_reg_write = ex_reg.reg_write;
  assign bus.ex_branch    = ex_reg.branch;
  assign bus.ex_jump      = ex_reg.jump;
  assign bus.ex_illegal   = ex_reg.illegal;
  assign bus.stall_active = (state_reg == ST_STALL);

endmodule
